// File: rtl/hazard_control_unit_pkg.sv
// Shared types and widths for the pipeline hazard control unit.
// Holds the stall FSM encoding and the register-match rule used by hazard detection.
package hazard_control_unit_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // Register 0 is hard-wired to zero, so it can never create a dependency.
    function automatic logic reg_match(
        input logic [REG_W-1:0] r,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rt
    );
        return (r != '0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter16.sv
// 16-bit event counter that increments on enable and sticks at all-ones.
// Asynchronous active-high reset.
module sat_counter16
    import hazard_control_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use / branch-operand hazard detection with stall sequencing and IF/ID flush control.
// Also keeps saturating counts of stall cycles and flushes.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [REG_W-1:0] IDEX_WriteReg,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             IFID_Branch,
    input  logic             BranchTaken,
    output logic             PCoff,
    output logic             IFIDWriteOff,
    output logic             IDEXBubble,
    output logic             IFIDFlush,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    state_t     state, state_next;
    logic [1:0] remain, remain_next;
    logic       dep, load_use, branch_alu, hazard, stall;
    logic [1:0] stall_len;

    assign dep        = reg_match(IDEX_WriteReg, IFID_Rs, IFID_Rt, IFID_UsesRt);
    assign load_use   = IDEX_MemRead && dep;
    assign branch_alu = IFID_Branch && IDEX_RegWrite && !IDEX_MemRead && dep;
    assign hazard     = load_use || branch_alu;
    // A branch compared in ID needs the loaded value one extra cycle later.
    assign stall_len  = (load_use && IFID_Branch) ? 2'd2 : 2'd1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= RUN;
            remain <= 2'd0;
        end else begin
            state  <= state_next;
            remain <= remain_next;
        end
    end

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        state_next  = state;
        remain_next = remain;
        stall       = 1'b0;
        case (state)
            RUN: begin
                if (hazard) begin
                    stall = 1'b1;
                    if (stall_len == 2'd2) begin
                        state_next  = STALL;
                        remain_next = stall_len - 2'd1;
                    end
                end
            end
            STALL: begin
                stall       = 1'b1;
                remain_next = remain - 2'd1;
                if (remain <= 2'd1) begin
                    state_next  = RUN;
                    remain_next = 2'd0;
                end
            end
            default: begin
                state_next  = RUN;
                remain_next = 2'd0;
            end
        endcase
    end

    assign PCoff        = stall;
    assign IFIDWriteOff = stall;
    assign IDEXBubble   = stall;
    // A stalled branch is re-presented after the stall, so the flush waits for it.
    assign IFIDFlush    = BranchTaken && !stall;

    sat_counter16 u_stall_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .inc   (PCoff),
        .count (StallCycles)
    );

    sat_counter16 u_flush_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .inc   (IFIDFlush),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: single-cycle vector table plus
// hand-written multi-cycle stall, flush, reset-abort and saturation sequences.
module tb_hazard_control_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        IDEX_MemRead, IDEX_RegWrite, IFID_UsesRt, IFID_Branch, BranchTaken;
    logic [4:0]  IDEX_WriteReg, IFID_Rs, IFID_Rt;
    logic        PCoff, IFIDWriteOff, IDEXBubble, IFIDFlush;
    logic [15:0] StallCycles, FlushCount;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic       memread;
        logic       regwrite;
        logic [4:0] wreg;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesrt;
        logic       branch;
        logic       taken;
        logic [3:0] exp;   // {PCoff, IFIDWriteOff, IDEXBubble, IFIDFlush}
    } vec_t;

    vec_t vecs[12];

    hazard_control_unit dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .IDEX_MemRead  (IDEX_MemRead),
        .IDEX_RegWrite (IDEX_RegWrite),
        .IDEX_WriteReg (IDEX_WriteReg),
        .IFID_Rs       (IFID_Rs),
        .IFID_Rt       (IFID_Rt),
        .IFID_UsesRt   (IFID_UsesRt),
        .IFID_Branch   (IFID_Branch),
        .BranchTaken   (BranchTaken),
        .PCoff         (PCoff),
        .IFIDWriteOff  (IFIDWriteOff),
        .IDEXBubble    (IDEXBubble),
        .IFIDFlush     (IFIDFlush),
        .StallCycles   (StallCycles),
        .FlushCount    (FlushCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic rw, input logic [4:0] wr,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic ur, input logic br, input logic tk);
        IDEX_MemRead  = mr;
        IDEX_RegWrite = rw;
        IDEX_WriteReg = wr;
        IFID_Rs       = rs;
        IFID_Rt       = rt;
        IFID_UsesRt   = ur;
        IFID_Branch   = br;
        BranchTaken   = tk;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {PCoff, IFIDWriteOff, IDEXBubble, IFIDFlush};
    endfunction

    task automatic pulse_reset();
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        int exp_stall;
        int exp_flush;

        vecs[0]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[1]  = '{1'b1, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1110};
        vecs[2]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[3]  = '{1'b1, 1'b0, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[4]  = '{1'b1, 1'b0, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 4'b1110};
        vecs[5]  = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 4'b1110};
        vecs[6]  = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 4'b0001};
        vecs[8]  = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 4'b1110};
        vecs[9]  = '{1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[10] = '{1'b1, 1'b0, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[11] = '{1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 4'b1110};

        // Time-zero / reset state, before any clock edge.
        Reset = 1'b1;
        idle();
        #1;
        check("reset_outs", {12'd0, outs()}, 16'h0000);
        check("reset_stallcnt", StallCycles, 16'h0000);
        check("reset_flushcnt", FlushCount, 16'h0000);
        #1;
        Reset = 1'b0;

        // Single-cycle table: every entry leaves the FSM in RUN.
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            drive(vecs[i].memread, vecs[i].regwrite, vecs[i].wreg, vecs[i].rs,
                  vecs[i].rt, vecs[i].usesrt, vecs[i].branch, vecs[i].taken);
            #3;
            check($sformatf("vec%0d", i), {12'd0, outs()}, {12'd0, vecs[i].exp});
            exp_stall += int'(vecs[i].exp[3]);
            exp_flush += int'(vecs[i].exp[0]);
        end
        step();
        idle();
        #3;
        check("table_stallcnt", StallCycles, 16'(exp_stall));
        check("table_flushcnt", FlushCount, 16'(exp_flush));

        // Load-use: exactly one stall cycle.
        pulse_reset();
        step();
        drive(1'b1, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        #3;
        check("lu_c1", {12'd0, outs()}, 16'h000E);
        step();
        idle();
        #3;
        check("lu_c2", {12'd0, outs()}, 16'h0000);
        check("lu_stallcnt", StallCycles, 16'd1);

        // Load feeding a branch: two stall cycles, cycle-2 inputs ignored.
        pulse_reset();
        step();
        drive(1'b1, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
        #3;
        check("lb_c1", {12'd0, outs()}, 16'h000E);
        step();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        #3;
        check("lb_c2", {12'd0, outs()}, 16'h000E);
        step();
        idle();
        #3;
        check("lb_c3", {12'd0, outs()}, 16'h0000);
        check("lb_stallcnt", StallCycles, 16'd2);

        // Branch-ALU hazard with a taken branch: flush deferred past the stall.
        pulse_reset();
        step();
        drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
        #3;
        check("ba_c1", {12'd0, outs()}, 16'h000E);
        step();
        drive(1'b0, 1'b0, 5'd6, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
        #3;
        check("ba_c2", {12'd0, outs()}, 16'h0001);
        step();
        idle();
        #3;
        check("ba_flushcnt", FlushCount, 16'd1);
        check("ba_stallcnt", StallCycles, 16'd1);

        // Reset during a two-cycle stall aborts it.
        pulse_reset();
        step();
        drive(1'b1, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
        #3;
        step();
        idle();
        #1;
        check("rs_in_stall", {12'd0, outs()}, 16'h000E);
        Reset = 1'b1;
        #1;
        check("rs_high_outs", {12'd0, outs()}, 16'h0000);
        check("rs_high_stallcnt", StallCycles, 16'd0);
        #1;
        Reset = 1'b0;
        step();
        #3;
        check("rs_after_outs", {12'd0, outs()}, 16'h0000);
        check("rs_after_stallcnt", StallCycles, 16'd0);
        check("rs_after_flushcnt", FlushCount, 16'd0);

        // Saturation: a held load-use hazard stalls every cycle.
        pulse_reset();
        step();
        drive(1'b1, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 65540; c++) begin
            step();
        end
        #3;
        check("sat_stallcnt", StallCycles, 16'hFFFF);
        check("sat_flushcnt", FlushCount, 16'h0000);
        check("sat_outs", {12'd0, outs()}, 16'h000E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
